// File: rtl/basys3_countdown_timer_if.sv
// rtl/basys3_countdown_timer_if.sv - control pulses and display outputs of the countdown timer
// The master drives the button pulses; the slave is the timer producing digits and enables.
interface basys3_countdown_timer_if;
    logic        load_i;
    logic [15:0] load_digits_i;
    logic        start_i;
    logic        stop_i;
    logic [3:0]  digit0_o;
    logic [3:0]  digit1_o;
    logic [3:0]  digit2_o;
    logic [3:0]  digit3_o;
    logic        digit0_en_o;
    logic        digit1_en_o;
    logic        digit2_en_o;
    logic        digit3_en_o;
    logic        running_o;
    logic        done_o;

    modport master (
        output load_i, load_digits_i, start_i, stop_i,
        input  digit0_o, digit1_o, digit2_o, digit3_o,
        input  digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o,
        input  running_o, done_o
    );

    modport slave (
        input  load_i, load_digits_i, start_i, stop_i,
        output digit0_o, digit1_o, digit2_o, digit3_o,
        output digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o,
        output running_o, done_o
    );
endinterface

// File: rtl/basys3_countdown_timer.sv
// rtl/basys3_countdown_timer.sv - MM:SS BCD countdown timer with blinking expiry display
// Feeds the seven-segment driver directly on the shared 1 kHz clock.
module basys3_countdown_timer #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int BLINK_TICKS   = 500,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                      clk_1k_i,
    input  logic                      rst_i,
    basys3_countdown_timer_if.slave   ctl
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   count_dec;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          running_q, done_q;
    logic [3:0]    en;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r[15:12] = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
        r[11:8]  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        r[7:4]   = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
        r[3:0]   = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        return r;
    endfunction

    // Only evaluated while the count is non-zero, so min tens never underflows.
    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign count_dec = dec_bcd(count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        blink_d = blink_q;
        phase_d = phase_q;
        if (ctl.load_i) begin
            count_d = clamp_bcd(ctl.load_digits_i);
            presc_d = '0;
            blink_d = '0;
            phase_d = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    // A simultaneous stop outranks start, even where stop itself has no effect.
                    if (ctl.start_i && !ctl.stop_i && count_q != 16'h0000) state_d = RUN;
                end
                RUN: begin
                    if (ctl.stop_i) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        count_d = count_dec;
                        if (count_dec == 16'h0000) begin
                            state_d = DONE;
                            blink_d = '0;
                            phase_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                DONE: begin
                    if (blink_q == BLINK_LAST) begin
                        blink_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        blink_d = blink_q + BW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1k_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= 16'h0000;
            presc_q   <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    always_comb begin
        en = {~(BLANK_LEADING && count_q[15:12] == 4'd0), 3'b111};
        if (state_q == DONE) en = {4{phase_q}};
    end

    assign ctl.digit0_o    = count_q[3:0];
    assign ctl.digit1_o    = count_q[7:4];
    assign ctl.digit2_o    = count_q[11:8];
    assign ctl.digit3_o    = count_q[15:12];
    assign ctl.digit0_en_o = en[0];
    assign ctl.digit1_en_o = en[1];
    assign ctl.digit2_en_o = en[2];
    assign ctl.digit3_en_o = en[3];
    assign ctl.running_o   = running_q;
    assign ctl.done_o      = done_q;
endmodule

// File: tb/tb_basys3_countdown_timer.sv
// tb/tb_basys3_countdown_timer.sv - self-checking bench for basys3_countdown_timer
// Reference model tracks the count as total seconds and the blink as cycles since expiry.
module tb_basys3_countdown_timer;
    localparam int T = 4;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    basys3_countdown_timer_if bus();

    basys3_countdown_timer #(
        .TICKS_PER_SEC(T),
        .BLINK_TICKS(B),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clk_1k_i(clk),
        .rst_i(rst),
        .ctl(bus)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 run, 2 pause, 3 done
    int m_state, m_secs, m_presc, m_done_cnt;

    typedef struct {
        logic        ld;
        logic [15:0] dg;
        logic        st;
        logic        sp;
        logic [15:0] exp_digits;
        logic [3:0]  exp_en;
        logic        exp_run;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int nib_clamp(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [15:0] m_digits();
        int mins;
        mins = m_secs / 60;
        return {4'(mins / 10), 4'(mins % 10), 4'((m_secs % 60) / 10), 4'(m_secs % 10)};
    endfunction

    function automatic logic [3:0] m_en();
        logic [15:0] d;
        d = m_digits();
        if (m_state == 3) return (((m_done_cnt / B) % 2) == 0) ? 4'hF : 4'h0;
        return {(d[15:12] != 4'd0), 3'b111};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {bus.digit3_o, bus.digit2_o, bus.digit1_o, bus.digit0_o};
    endfunction

    function automatic logic [3:0] dut_en();
        return {bus.digit3_en_o, bus.digit2_en_o, bus.digit1_en_o, bus.digit0_en_o};
    endfunction

    task automatic model_reset();
        m_state = 0; m_secs = 0; m_presc = 0; m_done_cnt = 0;
    endtask

    task automatic model_step(input logic ld, input logic [15:0] dg, input logic st, input logic sp);
        if (ld) begin
            m_secs = (nib_clamp(int'(dg[15:12]), 9) * 10 + nib_clamp(int'(dg[11:8]), 9)) * 60
                   + nib_clamp(int'(dg[7:4]), 5) * 10 + nib_clamp(int'(dg[3:0]), 9);
            m_presc = 0; m_done_cnt = 0; m_state = 0;
        end else if (m_state == 0 || m_state == 2) begin
            if (st && !sp && m_secs != 0) m_state = 1;
        end else if (m_state == 1) begin
            if (sp) m_state = 2;
            else begin
                m_presc++;
                if (m_presc == T) begin
                    m_presc = 0;
                    m_secs--;
                    if (m_secs == 0) begin
                        m_state = 3;
                        m_done_cnt = 0;
                    end
                end
            end
        end else begin
            m_done_cnt++;
        end
    endtask

    task automatic check_model(input string name);
        chk(name, {10'h0, dut_digits(), dut_en(), bus.running_o, bus.done_o},
                  {10'h0, m_digits(), m_en(), (m_state == 1), (m_state == 3)});
    endtask

    task automatic step(input logic ld, input logic [15:0] dg, input logic st, input logic sp,
                        input string name);
        bus.load_i = ld; bus.load_digits_i = dg; bus.start_i = st; bus.stop_i = sp;
        @(posedge clk);
        model_step(ld, dg, st, sp);
        #1;
        bus.load_i = 1'b0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
        check_model(name);
    endtask

    task automatic idle_steps(input int n, input string name);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] blink_exp [7];
        logic       r_ld, r_st, r_sp;
        logic [15:0] r_dg;

        vecs[0] = '{1'b1, 16'hFA7C, 1'b0, 1'b0, 16'h9959, 4'b1111, 1'b0};
        vecs[1] = '{1'b1, 16'h0930, 1'b0, 1'b0, 16'h0930, 4'b0111, 1'b0};
        vecs[2] = '{1'b1, 16'h0B6F, 1'b0, 1'b0, 16'h0959, 4'b0111, 1'b0};
        vecs[3] = '{1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h5959, 4'b1111, 1'b0};
        vecs[4] = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 4'b1111, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 4'b1111, 1'b1};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 4'b1111, 1'b0};
        vecs[7] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0111, 1'b0};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0111, 1'b0};
        blink_exp = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};

        bus.load_i = 1'b0; bus.load_digits_i = 16'h0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
        model_reset();
        #12;
        chk("reset_outputs", {10'h0, dut_digits(), dut_en(), bus.running_o, bus.done_o},
            {10'h0, 16'h0000, 4'b0111, 1'b0, 1'b0});
        #1 rst = 1'b0;

        // Borrow chain 01:05 -> 01:04 -> 00:59
        step(1'b1, 16'h0105, 1'b0, 1'b0, "load_0105");
        step(1'b0, 16'h0, 1'b1, 1'b0, "start_0105");
        chk("run_after_start", {31'h0, bus.running_o}, 32'h1);
        idle_steps(4, "count_0105");
        chk("first_dec", {16'h0, dut_digits()}, 32'h0104);
        idle_steps(20, "count_0104");
        chk("borrow_chain", {16'h0, dut_digits()}, 32'h0059);

        // Expiry and blink
        step(1'b1, 16'h0002, 1'b0, 1'b0, "load_0002");
        step(1'b0, 16'h0, 1'b1, 1'b0, "start_0002");
        idle_steps(4, "count_0002");
        chk("at_0001", {16'h0, dut_digits()}, 32'h0001);
        idle_steps(4, "count_0001");
        chk("expiry", {10'h0, dut_digits(), 4'h0, bus.running_o, bus.done_o},
            {10'h0, 16'h0000, 4'h0, 1'b0, 1'b1});
        for (int i = 0; i < 7; i++) begin
            if (i > 0) idle_steps(1, "blink");
            chk($sformatf("blink_en_%0d", i), {28'h0, dut_en()}, {28'h0, blink_exp[i]});
        end

        // Pause with held prescaler 2, resume decrements 2 edges later
        step(1'b1, 16'h0010, 1'b0, 1'b0, "load_0010");
        step(1'b0, 16'h0, 1'b1, 1'b0, "start_0010");
        idle_steps(2, "run_0010");
        step(1'b0, 16'h0, 1'b0, 1'b1, "stop_0010");
        idle_steps(10, "pause_hold");
        chk("pause_hold_digits", {16'h0, dut_digits()}, 32'h0010);
        step(1'b0, 16'h0, 1'b1, 1'b0, "resume");
        idle_steps(1, "resume_1");
        chk("resume_no_dec_yet", {16'h0, dut_digits()}, 32'h0010);
        idle_steps(1, "resume_2");
        chk("resume_dec", {16'h0, dut_digits()}, 32'h0009);

        // Table-driven load/clamp/blanking/priority vectors
        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].dg, vecs[i].st, vecs[i].sp, $sformatf("tbl_model_%0d", i));
            chk($sformatf("tbl_%0d", i), {11'h0, dut_digits(), dut_en(), bus.running_o},
                {11'h0, vecs[i].exp_digits, vecs[i].exp_en, vecs[i].exp_run});
        end

        // Stop on the wrap edge: no decrement, held at last prescaler value
        step(1'b1, 16'h0003, 1'b0, 1'b0, "load_0003");
        step(1'b0, 16'h0, 1'b1, 1'b0, "start_0003");
        idle_steps(3, "run_0003");
        step(1'b0, 16'h0, 1'b0, 1'b1, "stop_at_wrap");
        chk("stop_at_wrap", {15'h0, dut_digits(), bus.running_o}, {15'h0, 16'h0003, 1'b0});
        step(1'b0, 16'h0, 1'b1, 1'b0, "resume_wrap");
        idle_steps(1, "resume_wrap_1");
        chk("resume_wrap_dec", {16'h0, dut_digits()}, 32'h0002);

        // Load on the expiring edge wins
        step(1'b1, 16'h0001, 1'b0, 1'b0, "load_0001");
        step(1'b0, 16'h0, 1'b1, 1'b0, "start_0001");
        idle_steps(3, "run_0001");
        step(1'b1, 16'h0042, 1'b0, 1'b0, "load_at_expiry");
        chk("load_at_expiry", {14'h0, dut_digits(), bus.running_o, bus.done_o},
            {14'h0, 16'h0042, 1'b0, 1'b0});

        // Randomized traffic against the model
        step(1'b1, 16'h0012, 1'b0, 1'b0, "rand_init");
        for (int i = 0; i < 400; i++) begin
            r_ld = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) r_dg = 16'($urandom);
            else r_dg = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            r_st = ($urandom_range(0, 4) == 0);
            r_sp = ($urandom_range(0, 11) == 0);
            step(r_ld, r_dg, r_st, r_sp, "random");
        end

        // Asynchronous reset mid-RUN
        step(1'b1, 16'h0105, 1'b0, 1'b0, "load_pre_rst");
        step(1'b0, 16'h0, 1'b1, 1'b0, "start_pre_rst");
        idle_steps(2, "run_pre_rst");
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {10'h0, dut_digits(), dut_en(), bus.running_o, bus.done_o},
            {10'h0, 16'h0000, 4'b0111, 1'b0, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_model("after_reset");
        step(1'b0, 16'h0, 1'b1, 1'b0, "start_after_reset");
        chk("start_zero_ignored", {15'h0, dut_digits(), bus.running_o}, {15'h0, 16'h0000, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/basys3_countdown_timer.md
# basys3_countdown_timer

MM:SS countdown timer that produces the four BCD digits and per-digit enables for the Basys3 seven-segment driver. It runs on the same 1 kHz clock as the driver, so its digit/enable outputs connect port-for-port to the driver's digit inputs. The control inputs come from already-debounced, clock-synchronous single-cycle button pulses. On expiry the timer blinks the display.

## Interface
- TICKS_PER_SEC, default 1000: clock cycles per one-second decrement; legal range ≥ 2.
- BLINK_TICKS, default 500: cycles per blink half-period in DONE; legal range ≥ 1.
- BLANK_LEADING, default 1: when 1, digit3 is disabled while its value is 0.

Ports (one clock; reset is asynchronous and active-high):
- clk_1k_i  in  1  1 kHz system clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- load_i  in  1  single-cycle pulse; captures load_digits_i.
- load_digits_i  in  16  BCD {min tens, min ones, sec tens, sec ones}, [15:12] down to [3:0].
- start_i  in  1  single-cycle pulse; start or resume.
- stop_i  in  1  single-cycle pulse; pause.
- digit0_i..digit3_i outputs, named digit0_o..digit3_o  out  4 each  sec ones, sec tens, min ones, min tens.
- digit0_en_o..digit3_en_o  out  1 each  display enable per digit.
- running_o  out  1  high in RUN.
- done_o  out  1  high in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- Per-edge input priority: load_i > stop_i > start_i. Lower-priority pulses arriving on the same edge are ignored.
- load_i, in any state:
  - Capture digits with clamping: any nibble > 9 becomes 9; sec tens > 5 becomes 5.
  - Clear the prescaler and the blink counter.
  - Go to IDLE.
- start_i in IDLE or PAUSE:
  - If the count ≠ 00:00, go to RUN.
  - If the count = 00:00, ignore it.
- start_i in RUN or DONE: ignored.
- stop_i in RUN: go to PAUSE. The prescaler holds its value. Ignored in all other states.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1, in RUN only.
  - At TICKS_PER_SEC-1 it wraps to 0 and the count decrements by one second.
- Decrement arithmetic:
  - sec ones 0 → 9 with borrow; sec tens 0 → 5 with borrow; min ones 0 → 9 with borrow; min tens decrements.
  - Example: 10:00 → 09:59.
- Expiry: a decrement that produces 00:00 moves the block to DONE on the same edge. The count never wraps below 00:00.
- Enables in IDLE, RUN and PAUSE:
  - digit0..2_en = 1.
  - digit3_en = 0 when BLANK_LEADING=1 and digit3 = 0; otherwise 1.
- DONE blink:
  - The blink counter counts 0..BLINK_TICKS-1. On wrap it toggles a phase bit.
  - The phase bit is 1 on entry to DONE.
  - All four enables equal the phase bit; blanking is overridden.
  - DONE persists until load_i or reset.
- Reset, applied at any time including mid-count: all state clears immediately (asynchronous). No pending tick survives reset.

## Timing
- Reset values:
  - state IDLE; prescaler 0; blink counter 0; phase 1.
  - digit0..3_o = 0.
  - digit0..2_en_o = 1; digit3_en_o = 0 when BLANK_LEADING=1, else 1.
  - running_o = 0; done_o = 0.
- Output sourcing:
  - Digit outputs, running_o and done_o are direct register outputs.
  - Enables are combinational from registers only; there is no combinational input-to-output path.
- Input latency: a load/start/stop pulse sampled at edge N shows its effect on the outputs after edge N.
- Decrement timing:
  - After start at edge N with the prescaler at 0, the first decrement happens at edge N+TICKS_PER_SEC.
  - After a resume, the first decrement comes TICKS_PER_SEC minus the held prescaler value edges later.
- Expiry timing:
  - done_o rises on the same edge the count becomes 00:00, and running_o falls on that edge.
  - The first blink toggle (enables → 0) comes BLINK_TICKS edges later.
- stop_i and the prescaler wrap on the same edge: stop wins and no decrement occurs; the prescaler holds TICKS_PER_SEC-1.
- load_i on the same edge as the expiring decrement: load wins, and the block goes to IDLE with the new value.

## Test plan
Bench parameters: TICKS_PER_SEC=4, BLINK_TICKS=2.
- Reset, then load 0x0105 and start → 01:05; after 4 edges 01:04; after 20 more edges 00:59 (borrow chain).
- Load 0x0002 and start → 00:01 after 4 edges, 00:00 after 8 edges. On that edge done_o=1 and running_o=0. After that the enables read 1,1,0,0,1,1,... every edge pair.
- Start, stop after 2 edges, hold 10 edges, start → the count is unchanged during the pause, and the next decrement comes exactly 2 edges after the resume.
- Load 0xFA7C → clamped to 99:59, min tens=9, so digit3_en=1. Load 0x0930 → digit3_en=0.
- Load, start and stop pulsed together on one edge → IDLE with the new value, running_o=0. Start with load=0x0000 → stays in IDLE.
- Assert rst_i mid-RUN between clock edges → outputs go to their reset values immediately, without waiting for an edge. After release, start is ignored because the count is 00:00.
